bus_master_port: RTL and testbench
==================================

// Module: bus_master_port
// PURPOSE
//  Master-side initiator for the serial system bus. Accepts one parallel request and wins the bus
//  (mbreq/mbgrant). Shifts the device address onto mwdata for the address decoder, then waits for ack.
//  Sends the slave frame, then completes the write or collects serial read data, surviving split
//  transactions. Sits between a master core and the arbiter/decoder/slave mux.
// PARAMETERS
//  DEVICE_ADDR_WIDTH  4   device-select bits, sent first, LSB-first
//  ADDR_WIDTH         12  in-slave memory address bits
//  DATA_WIDTH         8   write/read data bits
//  ACK_TIMEOUT        16  cycles in ACKW without ack before error
//  MAX_RETRY          2   extra attempts after ack timeout (only with BUS_MPORT_RETRY_EN)
// PORTS
//  clk          in   1    system clock, all logic on posedge
//  rst          in   1    asynchronous reset, active-high
//  req_valid    in   1    core request valid
//  req_ready    out  1    high only in IDLE
//  req_write    in   1    1=write, 0=read
//  req_dev      in   DEVICE_ADDR_WIDTH  target device
//  req_addr     in   ADDR_WIDTH         memory address
//  req_wdata    in   DATA_WIDTH         write data
//  rsp_valid    out  1    one-cycle completion pulse
//  rsp_rdata    out  DATA_WIDTH         read data (held until next rsp_valid)
//  rsp_err      out  1    valid with rsp_valid; 1 = no ack
//  mbreq        out  1    bus request to arbiter
//  mbgrant      in   1    arbiter grant
//  mwdata       out  1    serial write bit
//  mvalid       out  1    serial bit valid
//  ack          in   1    decoder ack (slave selected and ready)
//  sready       in   1    selected slave ready
//  ssplit       in   1    slave split
//  split_grant  in   1    arbiter re-grant after split
//  srdata       in   1    serial read bit
//  srvalid      in   1    srdata valid
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; mbreq, mvalid, mwdata, rsp_valid, rsp_err = 0; rsp_rdata=0;
//    req_ready=1 immediately. All bus outputs are registered.
//  IDLE:  req_valid&req_ready -> latch request, clear retry count -> REQ.
//  REQ:   mbreq=1; mbgrant -> DEV. mbgrant loss after entering DEV is ignored.
//  DEV:   mvalid=1; mwdata=req_dev[k] for k=0..DEVICE_ADDR_WIDTH-1, one bit/cycle -> ACKW.
//  ACKW:  mvalid=0; timer counts from 0. ack=1 -> FRAME next cycle.
//    Timer reaches ACK_TIMEOUT -> DONE with rsp_err=1. If ack and timeout coincide, ack wins.
//  FRAME: mvalid=1 for 1+ADDR_WIDTH(+DATA_WIDTH if write) cycles. Bit order: req_write, then
//    addr LSB-first, then wdata LSB-first. Then write -> WRESP, read -> RDATA.
//  WRESP: mvalid=0; sready=1 -> DONE; ssplit=1 -> SPLIT (return state=WRESP). ssplit wins ties.
//  RDATA: each srvalid cycle shifts srdata into rsp_rdata LSB-first. After DATA_WIDTH bits -> DONE.
//    ssplit -> SPLIT with the bit count preserved. If srvalid and ssplit coincide, the bit is taken.
//  SPLIT: mbreq=0, mvalid=0. split_grant -> saved state, mbreq=1. No timeout.
//  DONE:  rsp_valid=1 one cycle; mbreq=0 -> IDLE.
//  Latency (no waits): request->mbreq 1 cycle. Write total =
//    grant + DEVICE_ADDR_WIDTH + ack wait + 1+ADDR_WIDTH+DATA_WIDTH + sready + 1.
//  Counters are sized $clog2(1+ADDR_WIDTH+DATA_WIDTH+1). Bit index saturates, never wraps.
// CONFIGURATION
//  BUS_MPORT_RETRY_EN defined: ack timeout with retry count < MAX_RETRY -> mbreq=0 for 1 cycle,
//    retry count +1, -> REQ (full re-arbitration and DEV resend). Error only after MAX_RETRY retries.
//  Undefined: ack timeout -> DONE with rsp_err=1 immediately. Retry counter is not built.
// STRUCTURE
//  Shared package bus_pkg holds:
//    - state encodings IDLE/REQ/DEV/ACKW/FRAME/WRESP/RDATA/SPLIT/DONE
//    - frame mode constants MODE_WRITE=1, MODE_READ=0
//  One sub-module, bus_piso: a loadable parallel-in serial-out shifter.
//    Loaded with {wdata,addr,mode} or dev; it drives mwdata and reports the last bit.
//  The FSM, timers and read shifter stay in bus_master_port.
// TESTING
//  1 write dev=1 addr=0x0A5 data=0x3C, grant next cycle:
//    mwdata 1,0,0,0 with mvalid=1; ack after 2 cycles.
//    Frame 1,addr LSB-first,0x3C LSB-first (21 bits); sready -> rsp_valid=1, rsp_err=0.
//  2 read dev=2 addr=0x010; slave returns 0x5A serially on srvalid (gaps of 1 cycle) ->
//    rsp_rdata=0x5A, rsp_err=0, exactly one rsp_valid.
//  3 dev=3, ack never asserted, macro off -> rsp_err=1 exactly 16 cycles after last DEV bit;
//    mbreq=0 in IDLE.
//  4 read with ssplit after 3 srvalid bits -> mbreq=0 next cycle. split_grant 20 cycles later ->
//    mbreq=1, remaining 5 bits complete 0xC3 correctly.
//  5 rst pulsed mid-FRAME -> mvalid=0, mbreq=0, req_ready=1 without clock edge.
//    Next write completes with err=0.
//  6 BUS_MPORT_RETRY_EN, MAX_RETRY=2, ack only on 2nd attempt ->
//    two DEV sequences with mbreq low 1 cycle between; rsp_err=0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared encodings for the serial system bus master port: FSM states and frame mode bit.
package bus_pkg;

  typedef enum logic [3:0] {
    IDLE, REQ, DEV, ACKW, FRAME, WRESP, RDATA, SPLIT, DONE
  } state_t;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

endpackage

// File: rtl/bus_piso.sv
// Loadable parallel-in serial-out shifter; bit 0 goes out first and o_last flags the final bit.
module bus_piso #(
  parameter int W  = 21,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [W-1:0]  i_data,
  input  logic [CW-1:0] i_len,
  input  logic          i_shift,
  output logic          o_bit,
  output logic          o_last
);

  logic [W-1:0]  r_sreg;
  logic [CW-1:0] r_rem;

  // The remaining-bit count saturates at zero; the register clears after the last bit so the line idles low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sreg <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_sreg <= i_data;
      r_rem  <= i_len - CW'(1);
    end else if (i_shift) begin
      if (r_rem == '0) begin
        r_sreg <= '0;
      end else begin
        r_sreg <= r_sreg >> 1;
        r_rem  <= r_rem - CW'(1);
      end
    end
  end

  assign o_bit  = r_sreg[0];
  assign o_last = (r_rem == '0);

endmodule

// File: rtl/bus_master_port.sv
// Serial system bus master: arbitrates, sends device select and frame, then completes write or read.
// Optional feature macro BUS_MPORT_RETRY_EN re-arbitrates after ack timeout up to MAX_RETRY times.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int ADDR_WIDTH        = 12,
  parameter int DATA_WIDTH        = 8,
  parameter int ACK_TIMEOUT       = 16
`ifdef BUS_MPORT_RETRY_EN
  , parameter int MAX_RETRY       = 2
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [DEVICE_ADDR_WIDTH-1:0] req_dev,
  input  logic [ADDR_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         rsp_valid,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         mbreq,
  input  logic                         mbgrant,
  output logic                         mwdata,
  output logic                         mvalid,
  input  logic                         ack,
  input  logic                         sready,
  input  logic                         ssplit,
  input  logic                         split_grant,
  input  logic                         srdata,
  input  logic                         srvalid,
  output state_t                       dbg_state
);

  localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_t                       r_state, r_ret;
  logic                         r_write;
  logic [DEVICE_ADDR_WIDTH-1:0] r_dev;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [DATA_WIDTH-1:0]        r_wdata, r_rshift, r_rsp_rdata;
  logic [TW-1:0]                r_timer;
  logic [CW-1:0]                r_rcnt;
  logic                         r_mbreq, r_mvalid, r_rsp_valid, r_rsp_err;
`ifdef BUS_MPORT_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0]                r_retry;
`endif

  logic          w_load, w_shift, w_bit, w_last;
  logic [FW-1:0] w_load_data;
  logic [CW-1:0] w_load_len;

  always_comb begin
    w_load      = ((r_state == REQ) && r_mbreq && mbgrant) || ((r_state == ACKW) && ack);
    w_shift     = (r_state == DEV) || (r_state == FRAME);
    w_load_data = {r_wdata, r_addr, r_write};
    w_load_len  = (r_write == MODE_WRITE) ? CW'(FW) : CW'(1 + ADDR_WIDTH);
    if (r_state == REQ) begin
      w_load_data = FW'(r_dev);
      w_load_len  = CW'(DEVICE_ADDR_WIDTH);
    end
  end

  bus_piso #(.W(FW), .CW(CW)) u_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_len   (w_load_len),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

  // Core handshake: a request transfers on the cycle req_valid and req_ready are both high; ready is high only in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ret       <= IDLE;
      r_write     <= MODE_READ;
      r_dev       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rshift    <= '0;
      r_rsp_rdata <= '0;
      r_timer     <= '0;
      r_rcnt      <= '0;
      r_mbreq     <= 1'b0;
      r_mvalid    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
`ifdef BUS_MPORT_RETRY_EN
      r_retry     <= '0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_write <= req_write;
          r_dev   <= req_dev;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_mbreq <= 1'b1;
          r_state <= REQ;
`ifdef BUS_MPORT_RETRY_EN
          r_retry <= '0;
`endif
        end
        // A grant is honoured only once our request is visible to the arbiter.
        REQ: begin
          r_mbreq <= 1'b1;
          if (r_mbreq && mbgrant) begin
            r_mvalid <= 1'b1;
            r_state  <= DEV;
          end
        end
        DEV: if (w_last) begin
          r_mvalid <= 1'b0;
          r_timer  <= '0;
          r_state  <= ACKW;
        end
        ACKW: if (ack) begin
          r_mvalid <= 1'b1;
          r_state  <= FRAME;
        end else if (r_timer == TW'(ACK_TIMEOUT - 1)) begin
`ifdef BUS_MPORT_RETRY_EN
          if (r_retry < RW'(MAX_RETRY)) begin
            r_retry <= r_retry + RW'(1);
            r_mbreq <= 1'b0;
            r_state <= REQ;
          end else
`endif
          begin
            r_mbreq     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_state     <= DONE;
          end
        end else begin
          r_timer <= r_timer + TW'(1);
        end
        FRAME: if (w_last) begin
          r_mvalid <= 1'b0;
          r_rcnt   <= '0;
          r_state  <= (r_write == MODE_WRITE) ? WRESP : RDATA;
        end
        WRESP: if (ssplit) begin
          r_ret   <= WRESP;
          r_mbreq <= 1'b0;
          r_state <= SPLIT;
        end else if (sready) begin
          r_mbreq     <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_state     <= DONE;
        end
        RDATA: begin
          if (srvalid) r_rshift <= {srdata, r_rshift[DATA_WIDTH-1:1]};
          if (srvalid && (r_rcnt == CW'(DATA_WIDTH - 1))) begin
            r_rsp_rdata <= {srdata, r_rshift[DATA_WIDTH-1:1]};
            r_mbreq     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_state     <= DONE;
          end else begin
            if (srvalid) r_rcnt <= r_rcnt + CW'(1);
            if (ssplit) begin
              r_ret   <= RDATA;
              r_mbreq <= 1'b0;
              r_state <= SPLIT;
            end
          end
        end
        SPLIT: if (split_grant) begin
          r_mbreq <= 1'b1;
          r_state <= r_ret;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mbreq     = r_mbreq;
  assign mvalid    = r_mvalid;
  assign mwdata    = w_bit;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: table of directed transactions plus random ones, bus side modelled reactively.
// Honours BUS_MPORT_RETRY_EN when the design is built with it.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int DAW = 4;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int TMO = 16;
`ifdef BUS_MPORT_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  localparam int PH_ARB = 0, PH_DEV = 1, PH_ACK = 2, PH_FRM = 3, PH_RSP = 4, PH_SPL = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req_valid = 1'b0, req_write = 1'b0;
  logic [DAW-1:0] req_dev = '0;
  logic [AW-1:0]  req_addr = '0;
  logic [DW-1:0]  req_wdata = '0;
  logic           mbgrant = 1'b0, ack = 1'b0, sready = 1'b0, ssplit = 1'b0;
  logic           split_grant = 1'b0, srdata = 1'b0, srvalid = 1'b0;
  logic           req_ready, rsp_valid, rsp_err, mbreq, mwdata, mvalid;
  logic [DW-1:0]  rsp_rdata;
  state_t         dbg_state;

  bus_master_port dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_dev(req_dev), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mbreq(mbreq), .mbgrant(mbgrant), .mwdata(mwdata), .mvalid(mvalid),
    .ack(ack), .sready(sready), .ssplit(ssplit), .split_grant(split_grant),
    .srdata(srdata), .srvalid(srvalid), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic           write;
    logic [DAW-1:0] dev;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  rdata;      // data the slave returns on a read
    int             grant_dly;  // REQ cycles before grant
    int             ack_dly;    // ACKW cycle index on which ack is given
    int             ack_try;    // attempt that gets acked (large = never)
    int             split_at;   // read: bits before split; write: 0 = split in WRESP; -1 none
    int             split_wait;
    int             rgap;       // idle cycles between srvalid bits
    bit             abort;      // reset pulse mid-frame
    logic           exp_err;
    logic [DW-1:0]  exp_rdata;
  } vec_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [0:0]    exp_q[$];
  logic [DW-1:0] last_rdata = '0;
  vec_t          tbl[9];

  task automatic check(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h required %0h", tag, name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, int dev, int addr, int wd, int rd, int gd, int ad, int at,
                              int sa, int sw, int rg, bit ab, bit ee, int erd);
    vec_t v;
    v.write = w;        v.dev = DAW'(dev);   v.addr = AW'(addr);
    v.wdata = DW'(wd);  v.rdata = DW'(rd);   v.grant_dly = gd;
    v.ack_dly = ad;     v.ack_try = at;      v.split_at = sa;
    v.split_wait = sw;  v.rgap = rg;         v.abort = ab;
    v.exp_err = ee;     v.exp_rdata = DW'(erd);
    return v;
  endfunction

  // Reference: device bits once per attempt, then the frame if some attempt is acked.
  task automatic model(input vec_t v, output logic e_err, output logic [DW-1:0] e_rd);
    bit acked;
    int n_att;
    acked = (v.ack_try <= RETRIES);
    n_att = acked ? v.ack_try + 1 : RETRIES + 1;
    exp_q.delete();
    for (int a = 0; a < n_att; a++)
      for (int k = 0; k < DAW; k++) exp_q.push_back(v.dev[k]);
    if (acked) begin
      exp_q.push_back(v.write);
      for (int k = 0; k < AW; k++) exp_q.push_back(v.addr[k]);
      if (v.write) for (int k = 0; k < DW; k++) exp_q.push_back(v.wdata[k]);
    end
    e_err = !acked;
    e_rd  = (!v.write && acked) ? v.rdata : last_rdata;
  endtask

  task automatic clear_bus();
    req_valid = 0; mbgrant = 0; ack = 0; sready = 0; ssplit = 0;
    split_grant = 0; srdata = 0; srvalid = 0;
  endtask

  task automatic run(input vec_t v, input bit use_tbl, input string tag);
    logic e_err, g_err;
    logic [DW-1:0] e_rd, g_rd;
    logic [0:0] eb;
    int ph, arb_cnt, ackw_cnt, attempt, bi, gap, sp_cnt, low_cnt, frm_bits;
    bit split_done, got;
    model(v, e_err, e_rd);
    if (use_tbl) begin
      e_err = v.exp_err;
      e_rd  = v.exp_rdata;
    end
    ph = PH_ARB; arb_cnt = 0; ackw_cnt = 0; attempt = 0; bi = 0; gap = 0;
    sp_cnt = 0; low_cnt = 0; frm_bits = 0; split_done = 0; got = 0;
    g_err = 0; g_rd = '0;
    @(negedge clk);
    check(tag, "ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_write = v.write; req_dev = v.dev; req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 0;
    check(tag, "req_to_mbreq", 32'(mbreq), 32'd1);
    check(tag, "ready_busy", 32'(req_ready), 32'd0);
    for (int cyc = 0; cyc < 600; cyc++) begin
      clear_bus();
      if (rsp_valid) begin
        if (ph == PH_ACK) check(tag, "timeout_pos", 32'(ackw_cnt), 32'(TMO));
        g_err = rsp_err; g_rd = rsp_rdata; got = 1;
        check(tag, "mbreq_done", 32'(mbreq), 32'd0);
        break;
      end
      case (ph)
        PH_ARB: if (mvalid) ph = PH_DEV;
        PH_DEV: if (!mvalid) begin ph = PH_ACK; ackw_cnt = 0; end
        PH_ACK: if (mvalid) ph = PH_FRM;
                else if (!mbreq) begin
                  check(tag, "retry_pos", 32'(ackw_cnt), 32'(TMO));
                  attempt++; ph = PH_ARB; arb_cnt = 0; low_cnt = 0;
                end
        PH_FRM: if (!mvalid) begin ph = PH_RSP; bi = 0; gap = 0; end
        default: ;
      endcase
      if (mvalid) begin
        if (ph == PH_FRM) frm_bits++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL %s.stream_extra: got bit %0b required none", tag, mwdata);
        end else begin
          eb = exp_q.pop_front();
          check(tag, "bit", 32'(mwdata), 32'(eb));
        end
      end
      if (v.abort && ph == PH_FRM && frm_bits == 5) begin
        #2 rst = 1;
        #1;
        check(tag, "rst_mvalid", 32'(mvalid), 32'd0);
        check(tag, "rst_mbreq", 32'(mbreq), 32'd0);
        check(tag, "rst_ready", 32'(req_ready), 32'd1);
        check(tag, "rst_rdata", 32'(rsp_rdata), 32'd0);
        #1 rst = 0;
        exp_q.delete();
        last_rdata = '0;
        return;
      end
      if (ph == PH_ARB) begin
        if (mbreq) begin
          if (attempt > 0 && arb_cnt == 0) check(tag, "retry_gap", 32'(low_cnt), 32'd1);
          mbgrant = (arb_cnt >= v.grant_dly);
          arb_cnt++;
        end else low_cnt++;
      end
      if (ph == PH_ACK) begin
        ack = (attempt == v.ack_try) && (ackw_cnt == v.ack_dly);
        ackw_cnt++;
      end
      if (ph == PH_SPL) begin
        if (sp_cnt == 0) check(tag, "split_mbreq_low", 32'(mbreq), 32'd0);
        if (sp_cnt == v.split_wait + 1) begin
          check(tag, "split_regrant", 32'(mbreq), 32'd1);
          ph = PH_RSP;
        end else begin
          split_grant = (sp_cnt == v.split_wait);
          sp_cnt++;
        end
      end
      if (ph == PH_RSP) begin
        if (bi == v.split_at && !split_done) begin
          ssplit = 1; split_done = 1; ph = PH_SPL; sp_cnt = 0;
        end else if (v.write) begin
          sready = 1;
        end else if (bi < DW) begin
          if (gap == 0) begin
            srvalid = 1; srdata = v.rdata[bi]; bi++; gap = v.rgap;
          end else gap--;
        end
      end
      @(negedge clk);
    end
    clear_bus();
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.rsp_timeout: got no rsp_valid required one within 600 cycles", tag);
      #2 rst = 1;
      #2 rst = 0;
      last_rdata = '0;
      exp_q.delete();
      return;
    end
    check(tag, "rsp_err", 32'(g_err), 32'(e_err));
    check(tag, "rsp_rdata", 32'(g_rd), 32'(e_rd));
    check(tag, "stream_left", 32'(exp_q.size()), 32'd0);
    last_rdata = e_rd;
    exp_q.delete();
    @(negedge clk);
    check(tag, "single_pulse", 32'(rsp_valid), 32'd0);
    check(tag, "idle_mbreq", 32'(mbreq), 32'd0);
    check(tag, "rdata_hold", 32'(rsp_rdata), 32'(e_rd));
  endtask

  initial begin
    vec_t rv;
    int r;
    clear_bus();
    #1 rst = 1;
    #1;
    check("reset", "req_ready", 32'(req_ready), 32'd1);
    check("reset", "mbreq", 32'(mbreq), 32'd0);
    check("reset", "mvalid", 32'(mvalid), 32'd0);
    check("reset", "mwdata", 32'(mwdata), 32'd0);
    check("reset", "rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset", "rsp_err", 32'(rsp_err), 32'd0);
    check("reset", "rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset", "state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 0;

    //            w  dev addr    wd     rd     gd ad  at  sa  sw  rg ab ee erd
    tbl[0] = mk(1, 1, 'h0A5, 'h3C, 'h00, 0, 2,  0, -1, 1,  0, 0, 0, 'h00);
    tbl[1] = mk(0, 2, 'h010, 'h00, 'h5A, 0, 1,  0, -1, 1,  1, 0, 0, 'h5A);
    tbl[2] = mk(0, 3, 'h234, 'h00, 'hFF, 0, 0,  7, -1, 1,  0, 0, 1, 'h5A);
    tbl[3] = mk(0, 5, 'h123, 'h00, 'hC3, 1, 0,  0,  3, 20, 0, 0, 0, 'hC3);
    tbl[4] = mk(1, 15,'hFFF, 'hFF, 'h00, 0, 15, 0, -1, 1,  0, 0, 0, 'hC3);
    tbl[5] = mk(1, 0, 'h5A5, 'hA5, 'h00, 3, 0,  0,  0, 3,  0, 0, 0, 'hC3);
    tbl[6] = mk(1, 6, 'h321, 'h81, 'h00, 0, 1,  0, -1, 1,  0, 1, 0, 'h00);
    tbl[7] = mk(1, 9, 'h456, 'h7E, 'h00, 2, 4,  0, -1, 1,  0, 0, 0, 'h00);
`ifdef BUS_MPORT_RETRY_EN
    tbl[8] = mk(0, 4, 'h00F, 'h00, 'h99, 0, 3,  1, -1, 1,  0, 0, 0, 'h99);
`else
    tbl[8] = mk(0, 4, 'h00F, 'h00, 'h99, 0, 3,  1, -1, 1,  0, 0, 1, 'h00);
`endif
    for (int i = 0; i < 9; i++) run(tbl[i], 1, $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.write = 1'($urandom_range(0, 1));
      rv.dev   = DAW'($urandom);
      rv.addr  = AW'($urandom);
      rv.wdata = DW'($urandom);
      rv.rdata = DW'($urandom);
      rv.grant_dly = $urandom_range(0, 3);
      rv.ack_dly   = $urandom_range(0, TMO - 1);
      r = $urandom_range(0, 9);
      rv.ack_try = (r < 7) ? 0 : ((r < 9) ? $urandom_range(1, 2) : 7);
      if ($urandom_range(0, 1) == 0) rv.split_at = -1;
      else rv.split_at = rv.write ? 0 : $urandom_range(0, DW - 1);
      rv.split_wait = $urandom_range(1, 25);
      rv.rgap  = $urandom_range(0, 2);
      rv.abort = 0;
      rv.exp_err = 0;
      rv.exp_rdata = '0;
      run(rv, 0, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
